// File: rtl/game_sequencer_pkg.sv
// game_pkg: shared encodings and defaults for the game sequencer.
//   game_state_t : top-level game mode (IDLE / PLAY / OVER), exported as game_state
//   pass_state_t : per-frame update pass (SEQ_IDLE -> PHYS -> OBST -> COLL)
//   STG_*        : bit positions of each subsystem in stage_start / stage_done
package game_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        PHYS     = 2'd1,
        OBST     = 2'd2,
        COLL     = 2'd3
    } pass_state_t;

    localparam int NUM_STAGES = 3;
    localparam int STG_PHYS   = 0;
    localparam int STG_OBST   = 1;
    localparam int STG_COLL   = 2;

    localparam int DEF_TIMEOUT_CYCLES = 1023;
    localparam int DEF_RESTART_FRAMES = 60;

    // Stage bit owned by a pass state; SEQ_IDLE maps to 0 but is never used.
    function automatic logic [1:0] stage_idx(input pass_state_t s);
        case (s)
            OBST:    return 2'(STG_OBST);
            COLL:    return 2'(STG_COLL);
            default: return 2'(STG_PHYS);
        endcase
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Stage handshake bundle between the sequencer and the game update blocks.
//   stage_start : one-hot single-cycle start per stage (sequencer -> datapath)
//   stage_done  : per-stage done (datapath -> sequencer)
//   collision   : collision result, valid while stage_done[STG_COLL] is high
interface game_sequencer_if;
    import game_pkg::*;

    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_done;
    logic                  collision;

    modport master (output stage_start, input stage_done, input collision);
    modport slave  (input stage_start, output stage_done, output collision);
endinterface

// File: rtl/game_sequencer_rise_detect.sv
// rise_detect: registered rising-edge detector.
//   clock, reset (async active-low), din (synchronous level)
//   rise : high in the cycle din is high and was low the cycle before
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic din_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) din_q <= 1'b0;
        else        din_q <= din;
    end

    assign rise = din & ~din_q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: per-frame controller. Each v_sync rising edge in PLAY runs
// one ordered pass physics -> obstacles -> collision over the stage handshake.
// Owns the game mode, the restart pulse and the sticky overrun flag.
//   clock, reset (async active-low)
//   v_sync, button : synchronous levels, rising edges are the events
//   stg            : stage_start / stage_done / collision handshake
//   restart        : single-cycle datapath reinitialise pulse
//   game_state     : 0 IDLE, 1 PLAY, 2 OVER
//   frame_count    : ticks seen in PLAY, wraps
//   overrun        : sticky; stage timeout or tick while a pass is busy
module game_sequencer
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int RESTART_FRAMES = DEF_RESTART_FRAMES,
    parameter int FRAME_W        = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   v_sync,
    input  logic                   button,
    game_sequencer_if.master       stg,
    output logic                   restart,
    output logic [1:0]             game_state,
    output logic [FRAME_W-1:0]     frame_count,
    output logic                   overrun
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int OVR_W = $clog2(RESTART_FRAMES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [OVR_W-1:0] OVR_SAT  = OVR_W'(RESTART_FRAMES);

    logic tick, press;

    rise_detect u_vs_rise (.clock(clock), .reset(reset), .din(v_sync), .rise(tick));
    rise_detect u_bt_rise (.clock(clock), .reset(reset), .din(button), .rise(press));

    pass_state_t           pass_q;
    game_state_t           game_q;
    logic [NUM_STAGES-1:0] start_q;
    logic                  restart_q;
    logic [FRAME_W-1:0]    frame_q;
    logic                  overrun_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [OVR_W-1:0]      over_q;

    logic [1:0] cur_idx;
    logic       cur_done;

    // start_q is high exactly in the first cycle of a stage, so a done seen
    // alongside it is the one to ignore. Other stages' done bits never reach here.
    always_comb begin
        cur_idx  = stage_idx(pass_q);
        cur_done = stg.stage_done[cur_idx] & ~start_q[cur_idx];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pass_q    <= SEQ_IDLE;
            game_q    <= GS_IDLE;
            start_q   <= '0;
            restart_q <= 1'b0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
            tmo_q     <= '0;
            over_q    <= '0;
        end else begin
            start_q   <= '0;
            restart_q <= 1'b0;

            // Pass sequencer
            case (pass_q)
                SEQ_IDLE: begin
                    if (game_q == GS_PLAY && tick) begin
                        pass_q            <= PHYS;
                        start_q[STG_PHYS] <= 1'b1;
                        tmo_q             <= '0;
                    end
                end
                default: begin
                    if (cur_done) begin
                        tmo_q <= '0;
                        case (pass_q)
                            PHYS: begin
                                pass_q            <= OBST;
                                start_q[STG_OBST] <= 1'b1;
                            end
                            OBST: begin
                                pass_q            <= COLL;
                                start_q[STG_COLL] <= 1'b1;
                            end
                            default: begin
                                // collision is sampled only at acceptance
                                pass_q <= SEQ_IDLE;
                                if (stg.collision) game_q <= GS_OVER;
                            end
                        endcase
                    end else if (tmo_q == TMO_LAST) begin
                        // abandon the rest of this frame; game mode untouched
                        pass_q    <= SEQ_IDLE;
                        overrun_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
            endcase

            // Game mode. Passes only exist in PLAY, so restart never races them.
            case (game_q)
                GS_IDLE: begin
                    if (press) begin
                        restart_q <= 1'b1;
                        game_q    <= GS_PLAY;
                        frame_q   <= '0;
                        overrun_q <= 1'b0;
                        over_q    <= '0;
                        tmo_q     <= '0;
                    end
                end
                GS_PLAY: begin
                    if (tick) begin
                        frame_q <= frame_q + 1'b1;
                        // includes the cycle a pass completes: still busy
                        if (pass_q != SEQ_IDLE) overrun_q <= 1'b1;
                    end
                end
                GS_OVER: begin
                    if (tick && over_q != OVR_SAT) over_q <= over_q + 1'b1;
                    if (press && over_q == OVR_SAT) begin
                        restart_q <= 1'b1;
                        game_q    <= GS_PLAY;
                        frame_q   <= '0;
                        overrun_q <= 1'b0;
                        over_q    <= '0;
                        tmo_q     <= '0;
                    end
                end
                default: game_q <= GS_IDLE;
            endcase
        end
    end

    assign stg.stage_start = start_q;
    assign restart         = restart_q;
    assign game_state      = game_q;
    assign frame_count     = frame_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios followed by a
// randomized phase, every cycle compared against an event-level model that
// tracks the active stage by entry cycle number.
module tb_game_sequencer;
    localparam int TMO = 8;
    localparam int RF  = 60;
    localparam int FW  = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          v_sync = 1'b0;
    logic          button = 1'b0;
    logic          restart, overrun;
    logic [1:0]    game_state;
    logic [FW-1:0] frame_count;

    game_sequencer_if stg ();

    game_sequencer #(.TIMEOUT_CYCLES(TMO), .RESTART_FRAMES(RF), .FRAME_W(FW)) dut (
        .clock(clock), .reset(reset), .v_sync(v_sync), .button(button), .stg(stg),
        .restart(restart), .game_state(game_state), .frame_count(frame_count), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       cyc;
    int       m_gs;       // 0 idle, 1 play, 2 over
    int       m_stage;    // -1 no pass, else active stage index
    int       m_entry;    // cycle number the active stage was entered
    int       m_frames;
    int       m_over;
    bit       m_ovr;
    bit       m_restart;
    bit [2:0] m_start;
    bit       m_vs_prev, m_bt_prev;

    task automatic model_reset();
        m_gs = 0; m_stage = -1; m_entry = 0; m_frames = 0; m_over = 0;
        m_ovr = 0; m_restart = 0; m_start = 0; m_vs_prev = 0; m_bt_prev = 0;
    endtask

    task automatic model_step();
        bit tk, pr, busy, to_over, sat;
        bit [2:0] n_start;
        tk = v_sync && !m_vs_prev;
        pr = button && !m_bt_prev;
        busy = (m_stage >= 0);
        to_over = 0;
        n_start = 0;
        m_restart = 0;
        if (m_stage >= 0) begin
            if (stg.stage_done[m_stage] && cyc > m_entry) begin
                if (m_stage == 2) begin
                    m_stage = -1;
                    to_over = stg.collision;
                end else begin
                    m_stage = m_stage + 1;
                    m_entry = cyc + 1;
                    n_start[m_stage] = 1'b1;
                end
            end else if (cyc - m_entry + 1 >= TMO) begin
                m_stage = -1;
                m_ovr = 1;
            end
        end
        case (m_gs)
            0: if (pr) begin
                m_restart = 1; m_gs = 1; m_frames = 0; m_ovr = 0; m_over = 0;
            end
            1: begin
                if (tk) begin
                    m_frames = (m_frames + 1) & ((1 << FW) - 1);
                    if (busy) m_ovr = 1;
                    else begin
                        m_stage = 0; m_entry = cyc + 1; n_start = 3'b001;
                    end
                end
                if (to_over) m_gs = 2;
            end
            default: begin
                sat = (m_over >= RF);
                if (tk && !sat) m_over = m_over + 1;
                if (pr && sat) begin
                    m_restart = 1; m_gs = 1; m_frames = 0; m_ovr = 0; m_over = 0;
                end
            end
        endcase
        m_start = n_start;
        m_vs_prev = v_sync;
        m_bt_prev = button;
    endtask

    // ---------------- stimulus helpers ----------------
    int       age = 100;
    int       act = 0;
    int       resp = 3;
    bit [2:0] hold = 3'b000;

    task automatic cycle();
        @(posedge clock);
        if (!reset) model_reset();
        else model_step();
        cyc++;
        #1;
        chk("stage_start", 32'(stg.stage_start), 32'(m_start));
        chk("restart", 32'(restart), 32'(m_restart));
        chk("game_state", 32'(game_state), 32'(m_gs));
        chk("frame_count", 32'(frame_count), 32'(m_frames));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // responder: done for the active stage 'resp' cycles after its start
    task automatic drive_done();
        if (|stg.stage_start) begin
            act = stg.stage_start[0] ? 0 : (stg.stage_start[1] ? 1 : 2);
            age = 1;
        end else if (age < 1000) begin
            age++;
        end
        stg.stage_done = 3'b000;
        if (age == resp && !hold[act]) stg.stage_done[act] = 1'b1;
    endtask

    task automatic step();
        cycle();
        drive_done();
    endtask

    initial begin
        stg.stage_done = 3'b000;
        stg.collision  = 1'b0;
        cyc = 0;
        model_reset();

        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_stage_start", 32'(stg.stage_start), 0);
        chk("rst_restart", 32'(restart), 0);
        chk("rst_game_state", 32'(game_state), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b1;

        // press -> restart + PLAY; tick -> first start, frame_count 1
        repeat (9) step();
        button = 1'b1; step(); button = 1'b0;
        chk("press_restart", 32'(restart), 1);
        chk("press_play", 32'(game_state), 1);
        v_sync = 1'b1; step(); v_sync = 1'b0;
        chk("tick_start", 32'(stg.stage_start), 32'h1);
        chk("tick_frame", 32'(frame_count), 1);
        repeat (14) step();
        chk("pass_still_play", 32'(game_state), 1);

        // second tick while the pass waits in PHYS
        hold = 3'b001;
        v_sync = 1'b1; step(); v_sync = 1'b0;
        step(); step();
        v_sync = 1'b1; step(); v_sync = 1'b0;
        chk("busy_overrun", 32'(overrun), 1);
        chk("busy_frame", 32'(frame_count), 3);
        chk("busy_no_start", 32'(stg.stage_start), 0);
        repeat (10) step();
        hold = 3'b000;

        // collision pass -> OVER, early presses ignored, restart after saturation
        stg.collision = 1'b1;
        v_sync = 1'b1; step(); v_sync = 1'b0;
        repeat (14) step();
        stg.collision = 1'b0;
        chk("coll_over", 32'(game_state), 2);
        for (int i = 0; i < RF; i++) begin
            v_sync = 1'b1; button = 1'b1; step();
            v_sync = 1'b0; button = 1'b0; repeat (3) step();
        end
        chk("over_hold", 32'(game_state), 2);
        button = 1'b1; step(); button = 1'b0;
        chk("over_restart", 32'(restart), 1);
        chk("over_play", 32'(game_state), 1);
        chk("over_frame_clr", 32'(frame_count), 0);
        chk("over_ovr_clr", 32'(overrun), 0);
        step();

        // timeout in OBST, then a fresh pass
        hold = 3'b010;
        v_sync = 1'b1; step(); v_sync = 1'b0;
        repeat (16) step();
        chk("tmo_overrun", 32'(overrun), 1);
        chk("tmo_play", 32'(game_state), 1);
        hold = 3'b000;
        v_sync = 1'b1; step(); v_sync = 1'b0;
        chk("tmo_fresh_start", 32'(stg.stage_start), 32'h1);
        repeat (14) step();

        // async reset mid-OBST
        hold = 3'b010;
        v_sync = 1'b1; step(); v_sync = 1'b0;
        repeat (6) step();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_start", 32'(stg.stage_start), 0);
        chk("mid_rst_state", 32'(game_state), 0);
        chk("mid_rst_frame", 32'(frame_count), 0);
        chk("mid_rst_ovr", 32'(overrun), 0);
        hold = 3'b000;
        stg.stage_done = 3'b010;
        repeat (2) begin cycle(); stg.stage_done = 3'b010; end
        reset = 1'b1;
        repeat (4) begin cycle(); stg.stage_done = 3'b010; end
        chk("post_rst_no_start", 32'(stg.stage_start), 0);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            v_sync         = ($urandom_range(0, 5) == 0);
            button         = ($urandom_range(0, 9) == 0);
            stg.collision  = ($urandom_range(0, 3) == 0);
            stg.stage_done = 3'($urandom) & 3'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Per-frame controller for the game datapath. It turns each vertical-sync rising edge into one ordered update pass over the three game subsystems: player physics, obstacle scroll and collision check. Each subsystem is started with a start/done handshake. The block also owns the game-level state (idle, play, game over), issues the restart pulse that reinitialises positions, and flags frame overruns. It sits between the VGA timing generator and the game update blocks.

## Interface
- TIMEOUT_CYCLES, 1023: maximum cycles a stage may take to assert done before the pass is aborted.
- RESTART_FRAMES, 60: frames that must elapse in game over before a button press is accepted.
- FRAME_W, 16: width of frame_count.

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- v_sync  in  1  vertical sync, active high, synchronous to clock.
- button  in  1  player button, level, already synchronised to clock.
- collision  in  1  collision result; valid in the cycle stage_done[2] is high.
- stage_done  in  3  per-stage done; bit 0 = physics, bit 1 = obstacles, bit 2 = collision.
- stage_start  out  3  one-hot, single-cycle start pulse per stage.
- restart  out  1  single-cycle pulse that reinitialises the datapath (player pixel_pos back to 265, etc.).
- game_state  out  2  0 = IDLE, 1 = PLAY, 2 = OVER.
- frame_count  out  FRAME_W  count of frame ticks seen in PLAY; wraps.
- overrun  out  1  sticky error flag: stage timeout, or tick arriving while a pass is busy.

## Operation
- Edge detection:
  - tick = v_sync high and registered v_sync low.
  - press = button high and registered button low.
- Game FSM:
  - IDLE, on press: pulse restart, go to PLAY.
  - PLAY, on tick: if the pass FSM is idle, start a pass and increment frame_count; if it is busy, set overrun and drop the tick (frame_count still increments).
  - PLAY to OVER: when a pass completes with collision sampled as 1.
  - OVER: the over-frame counter counts ticks and saturates at RESTART_FRAMES. A press once saturated pulses restart and goes to PLAY. A press before saturation is ignored.
- Restart pulse effects: clears frame_count, overrun, the over-frame counter and the timeout counter.
- Pass FSM: SEQ_IDLE → PHYS → OBST → COLL → SEQ_IDLE.
  - Entering a stage asserts its stage_start bit for exactly the first cycle in that stage.
  - Done is honoured from the cycle after start. Done asserted in the start cycle is ignored.
  - Done bits for inactive stages are ignored.
  - collision is latched when stage_done[2] is accepted.
- Timeout: a per-stage counter clears on stage entry. If it reaches TIMEOUT_CYCLES without done: set overrun, return to SEQ_IDLE, leave game_state unchanged, no further starts that frame.
- No passes run in IDLE or OVER. A tick in those states starts nothing and does not touch frame_count.
- Simultaneous events:
  - press and tick in the same IDLE cycle: restart wins; no pass is started for that tick.
  - collision pass completing in the same cycle as a tick: the tick is counted as busy (overrun set); the transition to OVER still happens.

## Timing
- Reset (asynchronous, immediate):
  - stage_start = 0, restart = 0, game_state = IDLE, frame_count = 0, overrun = 0.
  - Pass FSM to SEQ_IDLE; all counters and edge registers cleared.
  - Reset asserted mid-pass aborts the pass with no further pulses.
- Start of a pass: tick sampled at edge T → stage_start[0] high in cycle T+1 → frame_count updated at T+1.
- Stage hand-off: stage_done[i] accepted at edge D → stage_start[i+1] high in cycle D+1.
- End of pass: stage_done[2] at D → SEQ_IDLE at D+1; game_state = OVER at D+1 if collision was set.
- Pass latency: minimum 6 cycles from tick to SEQ_IDLE (start plus done one cycle later, for each of 3 stages).
- Restart: press at edge P → restart high in cycle P+1 and game_state = PLAY in cycle P+1.
- All outputs are registered.

## Structure
- Package game_pkg holds:
  - game_state encoding (IDLE/PLAY/OVER)
  - pass FSM state encoding
  - stage index constants (STG_PHYS = 0, STG_OBST = 1, STG_COLL = 2)
  - default TIMEOUT_CYCLES and RESTART_FRAMES
- Sub-module: rise_detect (registered rising-edge detector), instantiated twice (v_sync, button).

## Test plan
- Reset, press at cycle 10 → restart pulse at 11, game_state = 1; v_sync rises → stage_start = 001 one cycle later, frame_count = 1.
- PLAY, each stage done 3 cycles after its start with collision = 0 → starts 001, 010, 100 in order, pass complete 12 cycles after tick, game_state stays 1.
- Pass with collision = 1 on stage_done[2] → game_state = 2 next cycle; presses during the next 59 ticks are ignored; press after tick 60 → restart and game_state = 1, frame_count = 0.
- Withhold stage_done[1] with TIMEOUT_CYCLES = 8 → overrun = 1 after 8 cycles in OBST, stage_start[2] never asserted, next tick starts a fresh pass.
- Second tick while the pass waits in PHYS → overrun = 1, no extra start pulse, frame_count still increments.
- Assert reset mid-OBST → all outputs 0 and game_state = 0 immediately; stage_done[1] after release is ignored.
